// File: rtl/pow_to_number.sv
// Decodes an exponent into the one-hot value 1 << pow by walking a single set bit
// one position per clock, with valid/ready handshakes on both sides.
module pow_to_number #(
   parameter int WIDTH = 8,
   parameter int POW_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [POW_W-1:0] pow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] number,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // One extra bit so the out-of-range compare cannot wrap when 2**POW_W == WIDTH.
   localparam logic [POW_W:0] LIMIT = (POW_W + 1)'(WIDTH);

   state_t             state, state_nxt;
   logic [POW_W-1:0]   cnt, cnt_nxt;
   logic [WIDTH-1:0]   number_nxt;
   logic               err_nxt;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_nxt  = state;
      cnt_nxt    = cnt;
      number_nxt = number;
      err_nxt    = err;
      in_ready   = 1'b0;
      out_valid  = 1'b0;

      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if ({1'b0, pow} >= LIMIT) begin
                  number_nxt = '0;
                  err_nxt    = 1'b1;
                  state_nxt  = DONE;
               end else begin
                  number_nxt = WIDTH'(1);
                  cnt_nxt    = pow;
                  err_nxt    = 1'b0;
                  state_nxt  = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end else begin
               number_nxt = number << 1;
               cnt_nxt    = cnt - POW_W'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update together.
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         number <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         number <= number_nxt;
         err    <= err_nxt;
      end
   end

endmodule
